gpio_bus_arb: RTL and testbench
===============================

# gpio_bus_arb

Two-master arbiter that shares one peripheral slave port, the GPIO block's Write/Addr/WData/RData interface, between the core's data port (m0) and a secondary master such as debug or DMA (m1). It sits between the masters and the slave, runs one transaction at a time with round-robin fairness, and returns read data with a one-cycle acknowledge pulse. It supports both slave read styles: combinational RData (latency 0) and registered RData (latency 1).

## Interface
- READ_LATENCY, 0, slave RData latency in cycles after the Addr cycle; must match the slave's memory-type setting; only 0 and 1 are legal
- ADDR_W, 32, address width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- m0_req / m1_req  in  1  request; held with its fields stable until the matching ack
- m0_write / m1_write  in  4  byte write strobes; 0 means read
- m0_addr / m1_addr  in  ADDR_W  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_ack / m1_ack  out  1  single-cycle completion pulse
- m0_rdata / m1_rdata  out  32  read data, valid while ack is high, held until that master's next ack
- s_write  out  4  slave byte strobes
- s_addr  out  ADDR_W  slave address
- s_wdata  out  32  slave write data
- s_rdata  in  32  slave read data

## Operation
- FSM states: IDLE, ACCESS, WAIT (present only when READ_LATENCY=1), RESP.
- IDLE
  - No request: stay in IDLE.
  - Any req high: choose a winner, register its write, addr and wdata onto s_*, record the winner, go to ACCESS.
- Arbitration
  - If only one req is high, that master wins.
  - If both are high, the master not granted last wins.
  - The last-grant pointer resets to m1, so m0 wins the first tie.
- ACCESS
  - s_write carries the winner's strobes for exactly this one cycle; the slave commits the write at the end of the cycle.
  - READ_LATENCY=0: capture s_rdata into the winner's rdata register at the end of the cycle, go to RESP.
  - READ_LATENCY=1: go to WAIT.
- WAIT: s_write=0; capture s_rdata at the end of the cycle, go to RESP.
- RESP
  - Assert the winner's ack for one cycle with s_write=0.
  - Update the last-grant pointer to the winner, go to IDLE.
- s_write is 0 in every state except ACCESS, so a write can never be repeated.
- s_addr and s_wdata hold their last value outside ACCESS; they change only on the transition IDLE→ACCESS.
- Writes also capture s_rdata; masters ignore rdata on writes.
- Requests are sampled in IDLE only.
  - A req held high in the cycle after its ack is treated as a new transaction.
  - A req raised during ACCESS, WAIT or RESP waits for IDLE.
- The non-winning master's ack stays 0 and its rdata is unchanged.

## Timing
- Reset values: state=IDLE, s_write=0, s_addr=0, s_wdata=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, last-grant=m1.
- Request seen in IDLE at cycle N:
  - ACCESS at N+1.
  - Ack at N+2 for READ_LATENCY=0, or N+3 for READ_LATENCY=1.
- Maximum throughput is one transaction per 3 cycles (READ_LATENCY=0) or 4 cycles (READ_LATENCY=1).
- Both masters requesting continuously are served in alternation; neither can wait longer than one other transaction.
- Reset mid-operation returns the FSM to IDLE with no ack issued.
  - A write whose ACCESS cycle coincides with the rst cycle may still commit in the slave.
  - Masters must re-issue the request after reset.
- Simultaneous req edge and ack: the master receiving the ack competes again in IDLE and loses any tie.

## Structure
- Shared package periph_pkg:
  - state enum arb_state_t {IDLE, ACCESS, WAIT, RESP}
  - master index typedef
  - READ_LATENCY legal-value constants
- Sub-module rr_pick2: combinational two-way round-robin selector with inputs req[1:0] and last, outputs gnt_idx and valid.
- A parameter check rejects READ_LATENCY values other than 0 and 1 at elaboration.

## Test plan
- Single write: m0 writes strobes 4'hF, addr 0x04, wdata 0x0000_00A5.
  - s_write=4'hF for exactly one cycle.
  - m0_ack pulses 2 cycles after the req was sampled.
  - A subsequent m1 read of 0x04 returns 0x0000_00A5.
- Registered read: READ_LATENCY=1, m1 reads 0x00 from a slave returning 0x1234_5678.
  - m1_ack 3 cycles after the req was sampled.
  - m1_rdata=0x1234_5678.
- Tie and fairness: both reqs held high for 6 transactions.
  - Grant order m0, m1, m0, m1, m0, m1.
  - No cycle with both acks high.
- Byte strobes: m1 writes strobes 4'b0100 with wdata 0xDEAD_BEEF.
  - s_write=4'b0100 for one cycle only.
  - s_wdata=0xDEAD_BEEF during ACCESS.
- Reset mid-operation: rst pulsed in WAIT.
  - No ack issued.
  - All outputs return to reset values the next cycle.
  - A re-issued req completes normally.
- Back-to-back: m0 keeps req high after its ack.
  - Its second ACCESS follows exactly one IDLE cycle after RESP.

Source files
------------

// File: rtl/periph_pkg.sv
// rtl/periph_pkg.sv - shared types and constants for the GPIO bus arbiter
// Contents: arbiter FSM state enum, master index type, legal READ_LATENCY values
// and a helper that validates a READ_LATENCY setting.
package periph_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // Index of a bus master: 0 = core data port, 1 = secondary master.
  typedef logic mst_idx_t;

  localparam mst_idx_t MST_M0 = 1'b0;
  localparam mst_idx_t MST_M1 = 1'b1;

  // Slave read styles: combinational RData or RData registered one cycle.
  localparam int READ_LAT_COMB = 0;
  localparam int READ_LAT_REG  = 1;

  function automatic bit read_latency_ok(input int lat);
    return (lat == READ_LAT_COMB) || (lat == READ_LAT_REG);
  endfunction

endpackage

// File: rtl/gpio_bus_arb_if.sv
// rtl/gpio_bus_arb_if.sv - bundle of both master ports and the shared slave port
// Signals:
//   m0_*/m1_* : req, write[3:0] strobes, addr, wdata (towards arbiter); ack, rdata (back)
//   s_*       : write[3:0], addr, wdata (arbiter to slave); rdata (slave to arbiter)
// Modports:
//   master : environment side (masters and slave memory) driving requests and s_rdata
//   slave  : arbiter side, serving the masters and driving the slave port
interface gpio_bus_arb_if #(
  parameter int ADDR_W = 32
);

  logic              m0_req;
  logic [3:0]        m0_write;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata;
  logic              m0_ack;
  logic [31:0]       m0_rdata;

  logic              m1_req;
  logic [3:0]        m1_write;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata;
  logic              m1_ack;
  logic [31:0]       m1_rdata;

  logic [3:0]        s_write;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata;
  logic [31:0]       s_rdata;

  modport master (
    output m0_req, m0_write, m0_addr, m0_wdata,
    output m1_req, m1_write, m1_addr, m1_wdata,
    output s_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  s_write, s_addr, s_wdata
  );

  modport slave (
    input  m0_req, m0_write, m0_addr, m0_wdata,
    input  m1_req, m1_write, m1_addr, m1_wdata,
    input  s_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output s_write, s_addr, s_wdata
  );

endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin selector
// Ports:
//   req[1:0] in  : request per master
//   last     in  : master granted most recently
//   gnt_idx  out : chosen master (meaningful only when valid)
//   valid    out : at least one request present
module rr_pick2
  import periph_pkg::*;
(
  input  logic [1:0] req,
  input  mst_idx_t   last,
  output mst_idx_t   gnt_idx,
  output logic       valid
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) begin
      // Tie: the master that did not win last time goes first.
      gnt_idx = ~last;
    end else if (req[1]) begin
      gnt_idx = MST_M1;
    end else begin
      gnt_idx = MST_M0;
    end
  end

endmodule

// File: rtl/gpio_bus_arb.sv
// rtl/gpio_bus_arb.sv - two-master round-robin arbiter for the GPIO slave port
// Parameters:
//   READ_LATENCY : slave RData latency after the Addr cycle (0 or 1)
//   ADDR_W       : address width
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : gpio_bus_arb_if.slave carrying m0_*, m1_* and s_* signals
module gpio_bus_arb
  import periph_pkg::*;
#(
  parameter int READ_LATENCY = 0,
  parameter int ADDR_W       = 32
) (
  input logic           clk,
  input logic           rst,
  gpio_bus_arb_if.slave bus
);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_read_latency
    $error("gpio_bus_arb: READ_LATENCY must be 0 or 1");
  end

  arb_state_t        state_q, state_d;
  mst_idx_t          last_q, last_d;
  mst_idx_t          win_q, win_d;
  logic [3:0]        s_write_q, s_write_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [31:0]       s_wdata_q, s_wdata_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d;
  logic [31:0]       m1_rdata_q, m1_rdata_d;

  mst_idx_t pick_idx;
  logic     pick_valid;
  logic     capture;

  rr_pick2 u_pick (
    .req     ({bus.m1_req, bus.m0_req}),
    .last    (last_q),
    .gnt_idx (pick_idx),
    .valid   (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    s_write_d  = 4'h0;       // strobes live for the ACCESS cycle only
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    capture    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACCESS;
          win_d   = pick_idx;
          if (pick_idx == MST_M1) begin
            s_write_d = bus.m1_write;
            s_addr_d  = bus.m1_addr;
            s_wdata_d = bus.m1_wdata;
          end else begin
            s_write_d = bus.m0_write;
            s_addr_d  = bus.m0_addr;
            s_wdata_d = bus.m0_wdata;
          end
        end
      end
      ACCESS: begin
        if (READ_LATENCY == READ_LAT_REG) begin
          state_d = WAIT;
        end else begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Read data and the ack are registered together so the ack cycle
    // (RESP) presents the freshly captured rdata.
    if (capture) begin
      if (win_q == MST_M1) begin
        m1_rdata_d = bus.s_rdata;
        m1_ack_d   = 1'b1;
      end else begin
        m0_rdata_d = bus.s_rdata;
        m0_ack_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= MST_M1;
      win_q      <= MST_M0;
      s_write_q  <= 4'h0;
      s_addr_q   <= '0;
      s_wdata_q  <= 32'h0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= 32'h0;
      m1_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      s_write_q  <= s_write_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign bus.s_write  = s_write_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_gpio_bus_arb.sv
// tb/tb_gpio_bus_arb.sv - self-checking bench for gpio_bus_arb (both read latencies)
module tb_gpio_bus_arb;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  always #5 clk = ~clk;

  gpio_bus_arb_if #(.ADDR_W(32)) if0 ();
  gpio_bus_arb_if #(.ADDR_W(32)) if1 ();

  gpio_bus_arb #(.READ_LATENCY(0), .ADDR_W(32)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  gpio_bus_arb #(.READ_LATENCY(1), .ADDR_W(32)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // Index [d][m]: d = DUT (0: comb slave, 1: registered slave), m = master.
  logic        req  [2][2];
  logic [3:0]  wr   [2][2];
  logic [31:0] addr [2][2];
  logic [31:0] wd   [2][2];
  logic        ack  [2][2];
  logic [31:0] rd   [2][2];
  logic [3:0]  sw   [2];
  logic [31:0] sa   [2];
  logic [31:0] swd  [2];
  logic [31:0] srd  [2];

  assign if0.m0_req = req[0][0];  assign if0.m0_write = wr[0][0];
  assign if0.m0_addr = addr[0][0]; assign if0.m0_wdata = wd[0][0];
  assign if0.m1_req = req[0][1];  assign if0.m1_write = wr[0][1];
  assign if0.m1_addr = addr[0][1]; assign if0.m1_wdata = wd[0][1];
  assign if1.m0_req = req[1][0];  assign if1.m0_write = wr[1][0];
  assign if1.m0_addr = addr[1][0]; assign if1.m0_wdata = wd[1][0];
  assign if1.m1_req = req[1][1];  assign if1.m1_write = wr[1][1];
  assign if1.m1_addr = addr[1][1]; assign if1.m1_wdata = wd[1][1];
  assign ack[0][0] = if0.m0_ack;  assign ack[0][1] = if0.m1_ack;
  assign ack[1][0] = if1.m0_ack;  assign ack[1][1] = if1.m1_ack;
  assign rd[0][0] = if0.m0_rdata; assign rd[0][1] = if0.m1_rdata;
  assign rd[1][0] = if1.m0_rdata; assign rd[1][1] = if1.m1_rdata;
  assign sw[0] = if0.s_write;  assign sa[0] = if0.s_addr;  assign swd[0] = if0.s_wdata;
  assign sw[1] = if1.s_write;  assign sa[1] = if1.s_addr;  assign swd[1] = if1.s_wdata;
  assign if0.s_rdata = srd[0];
  assign if1.s_rdata = srd[1];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = nw[8*b +: 8];
    return old;
  endfunction

  // Slave memories: DUT0 sees combinational RData, DUT1 registered RData.
  logic [31:0] mem [2][16];
  logic [31:0] rd1_q;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) mem[d][i] <= 32'h0;
      mem[1][0] <= 32'h1234_5678;
    end else begin
      for (int d = 0; d < 2; d++)
        if (sw[d] != 4'h0) mem[d][sa[d][5:2]] <= merge(mem[d][sa[d][5:2]], swd[d], sw[d]);
    end
    rd1_q <= mem[1][sa[1][5:2]];
  end
  assign srd[0] = mem[0][sa[0][5:2]];
  assign srd[1] = rd1_q;

  // Bus-level observations collected every cycle and judged by the main sequence.
  int         both_ack_cnt [2];
  int         dbl_write_cnt[2];
  int         sw_cycles    [2];
  logic [3:0] last_sw      [2];
  logic [31:0] last_swd    [2];
  logic [3:0] prev_sw      [2];
  initial begin
    for (int d = 0; d < 2; d++) begin
      both_ack_cnt[d] = 0; dbl_write_cnt[d] = 0; sw_cycles[d] = 0;
      last_sw[d] = 4'h0; last_swd[d] = 32'h0; prev_sw[d] = 4'h0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ack[d][0] && ack[d][1]) both_ack_cnt[d]++;
        if (sw[d] != 4'h0) begin
          sw_cycles[d]++;
          last_sw[d]  = sw[d];
          last_swd[d] = swd[d];
          if (prev_sw[d] != 4'h0) dbl_write_cnt[d]++;
        end
        prev_sw[d] = sw[d];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ref_mem [2][16];
  int writes_done [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction; starts and returns 1 time unit after a rising edge.
  // lat = rising edges from raising req to the cycle in which ack is seen.
  task automatic do_txn(input int d, input int m, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] dat, input bit keep,
                        output logic [31:0] rdat, output int lat);
    req[d][m] = 1'b1; wr[d][m] = w; addr[d][m] = a; wd[d][m] = dat;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!ack[d][m] && lat < 30);
    if (!ack[d][m]) begin
      n_cmp++; n_err++;
      $display("FAIL ack_timeout d%0d m%0d: got no ack required ack within 30 cycles", d, m);
      lat = -1;
    end else if (w != 4'h0) begin
      ref_mem[d][a[5:2]] = merge(ref_mem[d][a[5:2]], dat, w);
      writes_done[d]++;
    end
    rdat = rd[d][m];
    if (!keep) req[d][m] = 1'b0;
  endtask

  task automatic master_proc(input int d, input int m, input int n);
    logic [31:0] r, a, dat;
    logic [3:0]  w;
    int lat;
    int t;
    t = (d == 1) ? 4 : 3;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      w   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      a   = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      dat = $urandom;
      do_txn(d, m, w, a, dat, 1'b0, r, lat);
      if (lat > 0) begin
        if (w == 4'h0) chk($sformatf("rand_rdata d%0d m%0d", d, m), r, ref_mem[d][a[5:2]]);
        n_cmp++;
        if (lat < t - 1 || lat > 2 * t) begin
          n_err++;
          $display("FAIL rand_latency d%0d m%0d: got %0d required %0d..%0d", d, m, lat, t - 1, 2 * t);
        end
      end
    end
  endtask

  typedef struct {
    int          d;
    int          m;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] wdat;
    bit          has_rd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] r;
    int lat, sw0;
    int order[$];
    int ack_t[$];
    int cyc;

    tbl[0] = '{0, 0, 4'hF,    32'h04, 32'h0000_00A5, 1'b0, 32'h0,         2};
    tbl[1] = '{0, 1, 4'h0,    32'h04, 32'h0,         1'b1, 32'h0000_00A5, 2};
    tbl[2] = '{0, 1, 4'b0100, 32'h08, 32'hDEAD_BEEF, 1'b0, 32'h0,         2};
    tbl[3] = '{0, 0, 4'h0,    32'h08, 32'h0,         1'b1, 32'h00AD_0000, 2};
    tbl[4] = '{1, 1, 4'h0,    32'h00, 32'h0,         1'b1, 32'h1234_5678, 3};
    tbl[5] = '{1, 0, 4'b0011, 32'h00, 32'hFFFF_0000, 1'b0, 32'h0,         3};
    tbl[6] = '{1, 1, 4'h0,    32'h00, 32'h0,         1'b1, 32'h1234_0000, 3};
    tbl[7] = '{1, 0, 4'h0,    32'h00, 32'h0,         1'b1, 32'h1234_0000, 3};

    for (int d = 0; d < 2; d++) begin
      writes_done[d] = 0;
      for (int i = 0; i < 16; i++) ref_mem[d][i] = 32'h0;
      for (int m = 0; m < 2; m++) begin
        req[d][m] = 1'b0; wr[d][m] = 4'h0; addr[d][m] = 32'h0; wd[d][m] = 32'h0;
      end
    end
    ref_mem[1][0] = 32'h1234_5678;
    rst = 1'b1; mem_init = 1'b1;
    repeat (3) tick();
    rst = 1'b0; mem_init = 1'b0;

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset s_write d%0d", d), 32'(sw[d]), 32'h0);
      chk($sformatf("reset s_addr d%0d", d), sa[d], 32'h0);
      chk($sformatf("reset s_wdata d%0d", d), swd[d], 32'h0);
      chk($sformatf("reset acks d%0d", d), {30'h0, ack[d][1], ack[d][0]}, 32'h0);
      chk($sformatf("reset m0_rdata d%0d", d), rd[d][0], 32'h0);
      chk($sformatf("reset m1_rdata d%0d", d), rd[d][1], 32'h0);
    end

    // Tie and fairness on DUT0 straight out of reset: m0 must win first.
    req[0][0] = 1'b1; wr[0][0] = 4'h0; addr[0][0] = 32'h10;
    req[0][1] = 1'b1; wr[0][1] = 4'h0; addr[0][1] = 32'h14;
    cyc = 0;
    while (order.size() < 6 && cyc < 60) begin
      tick();
      cyc++;
      if (ack[0][0]) begin order.push_back(0); ack_t.push_back(cyc); end
      if (ack[0][1]) begin order.push_back(1); ack_t.push_back(cyc); end
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    chk("tie grant count", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("tie grant %0d", i), 32'(order[i]), 32'(i % 2));
    for (int i = 1; i < ack_t.size(); i++)
      chk($sformatf("tie ack spacing %0d", i), 32'(ack_t[i] - ack_t[i-1]), 32'd3);
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      sw0 = sw_cycles[tbl[i].d];
      do_txn(tbl[i].d, tbl[i].m, tbl[i].w, tbl[i].a, tbl[i].wdat, 1'b0, r, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      if (tbl[i].has_rd) chk($sformatf("vec%0d rdata", i), r, tbl[i].exp_rd);
      if (tbl[i].w != 4'h0) begin
        chk($sformatf("vec%0d s_write cycles", i), 32'(sw_cycles[tbl[i].d] - sw0), 32'd1);
        chk($sformatf("vec%0d s_write value", i), 32'(last_sw[tbl[i].d]), 32'(tbl[i].w));
        chk($sformatf("vec%0d s_wdata value", i), last_swd[tbl[i].d], tbl[i].wdat);
      end
      tick();
    end

    // Back-to-back on DUT0: req stays high through the ack.
    do_txn(0, 0, 4'h0, 32'h04, 32'h0, 1'b1, r, lat);
    do_txn(0, 0, 4'h0, 32'h08, 32'h0, 1'b0, r, lat);
    chk("back_to_back spacing", 32'(lat), 32'd3);
    chk("back_to_back rdata", r, 32'h00AD_0000);
    tick();

    // Reset during WAIT on DUT1.
    req[1][0] = 1'b1; wr[1][0] = 4'h0; addr[1][0] = 32'h0C;
    tick();                    // ACCESS
    tick();                    // WAIT
    chk("rst_mid no early ack", 32'(ack[1][0]), 32'h0);
    rst = 1'b1; req[1][0] = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_mid ack", {30'h0, ack[1][1], ack[1][0]}, 32'h0);
    chk("rst_mid s_write", 32'(sw[1]), 32'h0);
    chk("rst_mid s_addr", sa[1], 32'h0);
    chk("rst_mid s_wdata", swd[1], 32'h0);
    chk("rst_mid m0_rdata", rd[1][0], 32'h0);
    chk("rst_mid m1_rdata", rd[1][1], 32'h0);
    repeat (3) begin
      tick();
      chk("rst_mid later ack", 32'(ack[1][0]), 32'h0);
    end
    do_txn(1, 0, 4'h0, 32'h00, 32'h0, 1'b0, r, lat);
    chk("reissue latency", 32'(lat), 32'd3);
    chk("reissue rdata", r, ref_mem[1][0]);
    tick();

    for (int d = 0; d < 2; d++) begin
      fork
        master_proc(d, 0, 25);
        master_proc(d, 1, 25);
      join
      repeat (3) tick();
    end

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("both acks d%0d", d), 32'(both_ack_cnt[d]), 32'h0);
      chk($sformatf("repeated write d%0d", d), 32'(dbl_write_cnt[d]), 32'h0);
      chk($sformatf("write pulses d%0d", d), 32'(sw_cycles[d]), 32'(writes_done[d]));
      for (int i = 0; i < 16; i++)
        chk($sformatf("slave mem d%0d w%0d", d, i), mem[d][i], ref_mem[d][i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
